// File: rtl/xorwow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xorwow_pkg
// Description : Shared types, seed constants and step function for the
//               xorwow generator bank.
// Revision    : 1.0 - initial release
// ============================================================================
package xorwow_pkg;

    localparam logic [31:0] SEED_X   = 32'd123456789;
    localparam logic [31:0] SEED_Y   = 32'd362436069;
    localparam logic [31:0] SEED_Z   = 32'd521288629;
    localparam logic [31:0] SEED_W   = 32'd88675123;
    localparam logic [31:0] SEED_V   = 32'd5783321;
    localparam logic [31:0] WEYL_INC = 32'd362437;
    localparam logic [31:0] D_INIT   = 32'd6615241;
    localparam logic [31:0] GOLDEN   = 32'h9E3779B9;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] d;
    } xorwow_state_t;

    typedef struct packed {
        xorwow_state_t state;
        logic [31:0]   result;
    } xorwow_step_t;

    // Each channel starts from the classic seed whitened by a per-channel key
    function automatic xorwow_state_t default_seed(input logic [31:0] ch);
        logic [31:0]   k;
        xorwow_state_t s;
        k   = ch * GOLDEN;
        s.x = SEED_X ^ k;
        s.y = SEED_Y ^ k;
        s.z = SEED_Z ^ k;
        s.w = SEED_W ^ k;
        s.v = SEED_V ^ k;
        s.d = D_INIT;
        return s;
    endfunction

    function automatic xorwow_step_t xorwow_step(input xorwow_state_t s);
        xorwow_step_t r;
        logic [31:0]  t;
        t         = s.x ^ (s.x >> 2);
        r.state.x = s.y;
        r.state.y = s.z;
        r.state.z = s.w;
        r.state.w = s.v;
        r.state.v = (s.v ^ (s.v << 4)) ^ (t ^ (t << 1));
        r.state.d = s.d + WEYL_INC;
        r.result  = r.state.v + r.state.d;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xorwow_core.sv
`default_nettype none
// ============================================================================
// Module      : xorwow_core
// Description : One xorwow channel: state, valid/ready output register and
//               run-time seed port.
// Revision    : 1.0 - initial release
// ============================================================================
module xorwow_core
    import xorwow_pkg::*;
#(
    parameter int CH_IDX = 0,
    parameter int OUT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_seed_we,
    input  logic [159:0]       i_seed_data,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [OUT_W-1:0]   o_data
);

    localparam xorwow_state_t C_DEFAULT = default_seed(32'(CH_IDX));

    xorwow_state_t    r_state;
    logic             r_valid;
    logic [OUT_W-1:0] r_data;
    xorwow_step_t     w_step;
    logic             w_fire;

    assign w_step = xorwow_step(r_state);
    // Stepping on the consuming edge gives back-to-back words with no bubble
    assign w_fire = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_DEFAULT;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_seed_we) begin
            r_state <= (i_seed_data == '0) ? C_DEFAULT : {i_seed_data, D_INIT};
            r_valid <= 1'b0;
        end else if (w_fire) begin
            r_state <= w_step.state;
            r_valid <= 1'b1;
            r_data  <= w_step.result[31 -: OUT_W];
        end
    end

    generate
        if (OUT_W < 32) begin : g_unused
            logic w_unused_bits;
            assign w_unused_bits = ^w_step.result[31-OUT_W:0];
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/xorwow_bank.sv
`default_nettype none
// ============================================================================
// Module      : xorwow_bank
// Description : NUM_CH independent xorwow generators with per-channel
//               valid/ready outputs and run-time seeding. Optional delivered
//               word counters are enabled by defining XORWOW_BANK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module xorwow_bank
    import xorwow_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int OUT_W  = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    seed_valid,
    input  logic [CH_W-1:0]         seed_ch,
    input  logic [159:0]            seed_data,
    output logic [NUM_CH-1:0]       rand_valid,
    input  logic [NUM_CH-1:0]       rand_ready,
    output logic [NUM_CH*OUT_W-1:0] rand_data
`ifdef XORWOW_BANK_STATS_EN
    ,
    input  logic [CH_W-1:0]         stat_sel,
    output logic [31:0]             stat_count
`endif
);

    logic [NUM_CH-1:0] w_seed_we;
`ifdef XORWOW_BANK_STATS_EN
    logic [31:0]       w_stat_cnt [NUM_CH];
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // Out-of-range channel numbers match no instance and are dropped
        assign w_seed_we[c] = seed_valid && (32'(seed_ch) == 32'(c));

        xorwow_core #(
            .CH_IDX (c),
            .OUT_W  (OUT_W)
        ) u_core (
            .clk         (clk),
            .rst         (rst),
            .i_seed_we   (w_seed_we[c]),
            .i_seed_data (seed_data),
            .i_ready     (rand_ready[c]),
            .o_valid     (rand_valid[c]),
            .o_data      (rand_data[c*OUT_W +: OUT_W])
        );

`ifdef XORWOW_BANK_STATS_EN
        logic [31:0] r_stat_cnt;

        always_ff @(posedge clk) begin
            if (rst || w_seed_we[c]) begin
                r_stat_cnt <= '0;
            end else if (rand_valid[c] && rand_ready[c]) begin
                r_stat_cnt <= r_stat_cnt + 32'd1;
            end
        end

        assign w_stat_cnt[c] = r_stat_cnt;
`endif
    end

`ifdef XORWOW_BANK_STATS_EN
    always_comb begin
        stat_count = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (32'(stat_sel) == 32'(c)) begin
                stat_count = w_stat_cnt[c];
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_xorwow_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_xorwow_bank
// Description : Self-checking bench: a 4x32 and a 3x16 bank against a
//               reference model, plus hand-computed vector table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xorwow_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         sv1, sv2;
    logic [1:0]   sch1, sch2;
    logic [159:0] sdat1, sdat2;
    logic [3:0]   rdy1, val1;
    logic [2:0]   rdy2, val2;
    logic [127:0] dat1;
    logic [47:0]  dat2;
`ifdef XORWOW_BANK_STATS_EN
    logic [1:0]   ssel1, ssel2;
    logic [31:0]  scnt1, scnt2;
`endif

    int n_pass  = 0;
    int n_total = 0;

    xorwow_bank #(.NUM_CH(4), .OUT_W(32)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (sv1),
        .seed_ch    (sch1),
        .seed_data  (sdat1),
        .rand_valid (val1),
        .rand_ready (rdy1),
        .rand_data  (dat1)
`ifdef XORWOW_BANK_STATS_EN
        ,
        .stat_sel   (ssel1),
        .stat_count (scnt1)
`endif
    );

    xorwow_bank #(.NUM_CH(3), .OUT_W(16)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (sv2),
        .seed_ch    (sch2),
        .seed_data  (sdat2),
        .rand_valid (val2),
        .rand_ready (rdy2),
        .rand_data  (dat2)
`ifdef XORWOW_BANK_STATS_EN
        ,
        .stat_sel   (ssel2),
        .stat_count (scnt2)
`endif
    );

    // Reference model, index [instance][channel]
    logic [31:0] mx [2][4], my [2][4], mz [2][4], mw [2][4], mv [2][4], md [2][4];
    logic [31:0] mres [2][4], mcnt [2][4];
    logic        mval [2][4];

    task automatic m_default(input int i, input int c);
        logic [31:0] cc, k;
        cc = c;
        k  = cc * 32'h9E3779B9;
        mx[i][c] = 32'd123456789 ^ k;
        my[i][c] = 32'd362436069 ^ k;
        mz[i][c] = 32'd521288629 ^ k;
        mw[i][c] = 32'd88675123 ^ k;
        mv[i][c] = 32'd5783321 ^ k;
        md[i][c] = 32'd6615241;
    endtask

    task automatic m_step(input int i, input int c);
        logic [31:0] t;
        t = mx[i][c] ^ (mx[i][c] >> 2);
        mx[i][c] = my[i][c];
        my[i][c] = mz[i][c];
        mz[i][c] = mw[i][c];
        mw[i][c] = mv[i][c];
        mv[i][c] = (mv[i][c] ^ (mv[i][c] << 4)) ^ (t ^ (t << 1));
        md[i][c] = md[i][c] + 32'd362437;
        mres[i][c] = mv[i][c] + md[i][c];
    endtask

    task automatic m_edge(input int i, input int nch, input logic r, input logic sv,
                          input int sch, input logic [159:0] sd, input logic [3:0] rdy);
        for (int c = 0; c < nch; c++) begin
            if (r) begin
                m_default(i, c);
                mval[i][c] = 1'b0;
                mres[i][c] = '0;
                mcnt[i][c] = '0;
            end else if (sv && sch == c) begin
                if (sd == '0) begin
                    m_default(i, c);
                end else begin
                    {mx[i][c], my[i][c], mz[i][c], mw[i][c], mv[i][c]} = sd;
                    md[i][c] = 32'd6615241;
                end
                mval[i][c] = 1'b0;
                mcnt[i][c] = '0;
            end else begin
                if (mval[i][c] && rdy[c]) mcnt[i][c] = mcnt[i][c] + 32'd1;
                if (!mval[i][c] || rdy[c]) begin
                    m_step(i, c);
                    mval[i][c] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic check_all();
        logic [127:0] e1, m1;
        logic [47:0]  e2, m2;
        logic [3:0]   v1;
        logic [2:0]   v2;
        e1 = '0; m1 = '0; e2 = '0; m2 = '0;
        for (int c = 0; c < 4; c++) begin
            v1[c] = mval[0][c];
            if (mval[0][c]) begin
                e1[c*32 +: 32] = mres[0][c];
                m1[c*32 +: 32] = '1;
            end
        end
        for (int c = 0; c < 3; c++) begin
            v2[c] = mval[1][c];
            if (mval[1][c]) begin
                e2[c*16 +: 16] = mres[1][c][31:16];
                m2[c*16 +: 16] = '1;
            end
        end
        chk("valid1", val1, v1);
        chk("data1", dat1 & m1, e1);
        chk("valid2", val2, v2);
        chk("data2", dat2 & m2, e2);
`ifdef XORWOW_BANK_STATS_EN
        chk("stat1", scnt1, mcnt[0][ssel1]);
        chk("stat2", scnt2, (ssel2 < 2'd3) ? mcnt[1][ssel2] : 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge(0, 4, rst, sv1, int'(sch1), sdat1, rdy1);
        m_edge(1, 3, rst, sv2, int'(sch2), sdat2, {1'b0, rdy2});
        #1;
        check_all();
    endtask

    typedef struct {
        logic         r;
        logic         sv;
        logic [1:0]   sch;
        logic [159:0] sd;
        logic [3:0]   rdy;
        logic [3:0]   ev;
        int           ch;
        logic [31:0]  ew;
    } vec_t;

    localparam logic [159:0] MARSAGLIA =
        160'h075BCD15_159A55E5_1F123BB5_05491333_00583F19;

    vec_t        tbl [10];
    logic [31:0] hold;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 2'd0, 160'd0, 4'hF, 4'h0, 0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 2'd0, 160'd0, 4'hF, 4'h0, 3, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 2'd0, 160'd0, 4'hF, 4'hF, 0, 32'h0EB70507};
        tbl[3] = '{1'b0, 1'b1, 2'd2, MARSAGLIA, 4'hF, 4'b1011, -1, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 2'd0, 160'd0, 4'hF, 4'hF, 2, 32'h0EB70507};
        tbl[5] = '{1'b0, 1'b1, 2'd3, 160'd0, 4'hF, 4'b0111, -1, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 2'd0, 160'd0, 4'hF, 4'hF, -1, 32'h0};
        tbl[7] = '{1'b1, 1'b1, 2'd1, 160'h1234, 4'hF, 4'h0, 1, 32'h0};
        tbl[8] = '{1'b0, 1'b0, 2'd0, 160'd0, 4'hF, 4'hF, 0, 32'h0EB70507};
        tbl[9] = '{1'b0, 1'b0, 2'd0, 160'd0, 4'h0, 4'hF, -1, 32'h0};

        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 4; c++) begin
                m_default(i, c);
                mval[i][c] = 1'b0;
                mres[i][c] = '0;
                mcnt[i][c] = '0;
            end
        end

        rst = 1'b1; sv1 = 1'b0; sch1 = '0; sdat1 = '0; rdy1 = 4'hF;
        sv2 = 1'b0; sch2 = '0; sdat2 = '0; rdy2 = 3'h7;
`ifdef XORWOW_BANK_STATS_EN
        ssel1 = 2'd0; ssel2 = 2'd0;
`endif

        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].r; sv1 = tbl[i].sv; sch1 = tbl[i].sch;
            sdat1 = tbl[i].sd; rdy1 = tbl[i].rdy;
            tick();
            chk("tbl_valid", val1, tbl[i].ev);
            if (tbl[i].ch >= 0) chk("tbl_word", dat1[tbl[i].ch*32 +: 32], tbl[i].ew);
        end
        rst = 1'b0; sv1 = 1'b0; sdat1 = '0; rdy1 = 4'hF;
        tick();

        // Backpressure on channel 1: word held, others keep flowing
        hold = mres[0][1];
        rdy1 = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", dat1[63:32], hold);
            chk("stall_valid", val1[1], 1'b1);
        end
        rdy1 = 4'hF;

        // Out-of-range seed on the 3-channel bank, then a real reseed
        sv2 = 1'b1; sch2 = 2'd3; sdat2 = 160'h5;
        tick();
        sch2 = 2'd1; sdat2 = 160'hABCDEF;
        tick();
        sv2 = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            if (i >= 500) begin
                rdy1 = 4'($urandom_range(0, 15));
                rdy2 = 3'($urandom_range(0, 7));
            end
            tick();
        end
        rdy1 = 4'hF; rdy2 = 3'h7;

`ifdef XORWOW_BANK_STATS_EN
        rdy1 = 4'h0; sv1 = 1'b1; sch1 = 2'd0; sdat1 = '0;
        tick();
        sv1 = 1'b0;
        tick();
        rdy1 = 4'b0001;
        repeat (10) tick();
        rdy1 = 4'h0;
        tick();
        chk("stat_10", scnt1, 32'd10);
        sv1 = 1'b1;
        tick();
        sv1 = 1'b0;
        chk("stat_clr", scnt1, 32'd0);
        tick();
        force dut1.g_ch[0].r_stat_cnt = 32'hFFFFFFFF;
        mcnt[0][0] = 32'hFFFFFFFF;
        #1;
        release dut1.g_ch[0].r_stat_cnt;
        rdy1 = 4'b0001;
        tick();
        chk("stat_wrap", scnt1, 32'd0);
        ssel2 = 2'd3;
        #1;
        chk("stat_oor", scnt2, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
